norm_shift_pipe: RTL and testbench
==================================

Name: norm_shift_pipe

Overview:
- Parametrised, two-stage pipelined leading-one normaliser for the systolic-array MAC datapath.
- Takes an unsigned fraction and its biased exponent, and shifts the fraction left until its MSB is '1'.
- Never drives the exponent below the denormal floor; clamps instead and flags denormal results.
- Valid/ready handshaked with full backpressure; an opaque tag travels alongside each result.

Parameters:
- WIDTH, 10: fraction width in bits (≥2).
- EXP_W, 8: biased exponent width.
- TAG_W, 4: sideband tag width, passed through unchanged (≥1).
- SH_W, $clog2(WIDTH+1): width of the shift-amount field (derived, not overridden).

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: input transaction present.
- in_ready, output, 1: block can accept the input this cycle.
- in_frac, input, WIDTH: unnormalised fraction.
- in_exp, input, EXP_W: biased exponent of in_frac.
- in_tag, input, TAG_W: sideband tag.
- out_valid, output, 1: result present.
- out_ready, input, 1: downstream accepts the result.
- out_frac, output, WIDTH: normalised fraction.
- out_exp, output, EXP_W: adjusted exponent.
- out_shift, output, SH_W: number of bit positions actually shifted.
- out_zero, output, 1: in_frac was all zeros.
- out_denorm, output, 1: shift was clamped; result is denormal.
- out_tag, output, TAG_W: tag of this result.

Behaviour:
- Reset (synchronous, active-high):
  - Both stage valid bits clear; out_valid=0.
  - out_frac, out_exp, out_shift, out_zero, out_denorm and out_tag are all 0.
  - in_ready=1 in the first cycle after reset.
  - A reset asserted mid-stream discards all in-flight transactions; no partial output is produced.
- Pipeline:
  - S1 registers the input plus lz, the leading-zero count of in_frac (0..WIDTH).
  - S2 registers the shifted result; its registers drive the outputs directly.
  - Latency is exactly 2 cycles from an input handshake to out_valid when not stalled.
  - Throughput is 1 transaction per cycle.
- Handshake:
  - Input transfer occurs when in_valid&&in_ready; output transfer occurs when out_valid&&out_ready.
  - adv2 = !s2_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1 (combinational through both stages, no skid buffer).
  - While out_valid=1 and out_ready=0, all out_* signals hold stable.
  - Back-to-back transfers with out_ready held high cause no bubbles.
  - Output order always equals input order.
- Shift rules (lz = leading zeros of in_frac, e = in_exp):
  - in_frac==0: shift=0, out_frac=0, out_exp=0, out_zero=1, out_denorm=0.
  - e==0 (already denormal): shift=0, out_frac=in_frac, out_exp=0, out_denorm=1 if in_frac[WIDTH-1]==0, else 0.
  - lz ≤ e-1: shift=lz, out_exp=e-lz, out_denorm=0; out_frac MSB is 1.
  - lz > e-1 (underflow clamp): shift=e-1, out_exp=0, out_denorm=1.
  - out_frac = in_frac << shift, with zeros shifted in from the right.
  - out_shift = shift; out_tag = in_tag.
  - Exponent arithmetic is unsigned EXP_W bits; the clamp guarantees no wrap.
- Simultaneous events:
  - When S2 drains and S1 refills in the same cycle, both transfers occur.
  - A new input may enter S1 in the same cycle S1 moves to S2.

Test Plan:
- Normal shift (WIDTH=10): in_frac=10'b0001011000, in_exp=20 -> after 2 cycles, out_frac=10'b1011000000, out_exp=17, out_shift=3, out_zero=0, out_denorm=0.
- Already normalised and exact boundary:
  - in_frac=10'b1000000001, in_exp=5 -> out_shift=0, out_exp=5.
  - in_frac=10'b0000010000, in_exp=6 -> out_shift=5, out_exp=1, out_frac=10'b1000000000, out_denorm=0.
- Underflow clamp and zero:
  - in_frac=10'b0000010000, in_exp=3 -> out_shift=2, out_frac=10'b0001000000, out_exp=0, out_denorm=1.
  - in_frac=0, in_exp=40 -> out_zero=1, out_exp=0, out_frac=0.
  - in_exp=0, in_frac=10'b0011000000 -> out_shift=0, out_denorm=1.
- Backpressure: stream 6 tagged inputs (tags 0..5) with out_ready toggling 1,0,0,1,... -> in_ready falls once both stages are full; outputs hold stable while stalled; tags emerge in order 0..5 with none lost or duplicated.
- Full throughput: 16 consecutive inputs with out_ready=1 -> 16 consecutive out_valid cycles starting 2 cycles after the first input; in_ready stays 1 throughout.
- Reset mid-stream: assert rst for 1 cycle with both stages full -> next cycle out_valid=0, all outputs 0, in_ready=1; the next input appears exactly 2 cycles after it is accepted.

Source files
------------

// File: rtl/norm_shift_pipe.sv
// norm_shift_pipe: two-stage leading-one normaliser with exponent floor clamp.
// Stage 1 captures the operand and its leading-zero count; stage 2 holds the
// shifted result and drives the outputs. Valid/ready with full backpressure.
module norm_shift_pipe #(
    parameter int WIDTH = 10,
    parameter int EXP_W = 8,
    parameter int TAG_W = 4,
    parameter int SH_W  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_frac,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_frac,
    output logic [EXP_W-1:0] out_exp,
    output logic [SH_W-1:0]  out_shift,
    output logic             out_zero,
    output logic             out_denorm,
    output logic [TAG_W-1:0] out_tag
);

    // Common width for comparing/subtracting the exponent against the shift.
    localparam int CW = ((EXP_W > SH_W) ? EXP_W : SH_W) + 1;

    // Stage 1 registers
    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_frac_q;
    logic [EXP_W-1:0] s1_exp_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic [SH_W-1:0]  s1_lz_q;

    // Stage 2 registers (drive the outputs directly)
    logic             s2_valid_q;
    logic [WIDTH-1:0] out_frac_q;
    logic [EXP_W-1:0] out_exp_q;
    logic [SH_W-1:0]  out_shift_q;
    logic             out_zero_q;
    logic             out_denorm_q;
    logic [TAG_W-1:0] out_tag_q;

    // Next-state values
    logic [SH_W-1:0]  lz_d;
    logic [WIDTH-1:0] out_frac_d;
    logic [EXP_W-1:0] out_exp_d;
    logic [SH_W-1:0]  out_shift_d;
    logic             out_zero_d;
    logic             out_denorm_d;

    logic [CW-1:0]    e_ext;
    logic [CW-1:0]    lz_ext;
    logic             adv1;
    logic             adv2;

    assign adv2     = !s2_valid_q || out_ready;
    assign adv1     = !s1_valid_q || adv2;
    assign in_ready = adv1;

    assign out_valid  = s2_valid_q;
    assign out_frac   = out_frac_q;
    assign out_exp    = out_exp_q;
    assign out_shift  = out_shift_q;
    assign out_zero   = out_zero_q;
    assign out_denorm = out_denorm_q;
    assign out_tag    = out_tag_q;

    // Leading-zero count of the incoming fraction; the highest set bit wins.
    always_comb begin
        lz_d = SH_W'(WIDTH);
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (in_frac[i]) begin
                lz_d = SH_W'(WIDTH - 1 - i);
            end
        end
    end

    assign e_ext  = CW'(s1_exp_q);
    assign lz_ext = CW'(s1_lz_q);

    // Pick the shift: full normalisation, or clamp so the exponent stops at 0.
    always_comb begin
        out_shift_d  = '0;
        out_exp_d    = '0;
        out_zero_d   = 1'b0;
        out_denorm_d = 1'b0;
        if (s1_frac_q == '0) begin
            out_zero_d = 1'b1;
        end else if (s1_exp_q == '0) begin
            out_denorm_d = !s1_frac_q[WIDTH-1];
        end else if (lz_ext < e_ext) begin
            out_shift_d = s1_lz_q;
            out_exp_d   = EXP_W'(e_ext - lz_ext);
        end else begin
            // e-1 < lz <= WIDTH, so e-1 always fits in the shift field.
            out_shift_d  = SH_W'(e_ext - CW'(1));
            out_denorm_d = 1'b1;
        end
        out_frac_d = s1_frac_q << out_shift_d;
    end

    // Stage 1: accept a new operand whenever stage 1 is free or moving on.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_frac_q  <= '0;
            s1_exp_q   <= '0;
            s1_tag_q   <= '0;
            s1_lz_q    <= '0;
        end else if (adv1) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_frac_q <= in_frac;
                s1_exp_q  <= in_exp;
                s1_tag_q  <= in_tag;
                s1_lz_q   <= lz_d;
            end
        end
    end

    // Stage 2: load the shifted result; outputs hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q   <= 1'b0;
            out_frac_q   <= '0;
            out_exp_q    <= '0;
            out_shift_q  <= '0;
            out_zero_q   <= 1'b0;
            out_denorm_q <= 1'b0;
            out_tag_q    <= '0;
        end else if (adv2) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_frac_q   <= out_frac_d;
                out_exp_q    <= out_exp_d;
                out_shift_q  <= out_shift_d;
                out_zero_q   <= out_zero_d;
                out_denorm_q <= out_denorm_d;
                out_tag_q    <= s1_tag_q;
            end
        end
    end

endmodule

// File: tb/tb_norm_shift_pipe.sv
// Directed bench for norm_shift_pipe at WIDTH=10, EXP_W=8, TAG_W=4.
module tb_norm_shift_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] in_frac;
    logic [7:0] in_exp;
    logic [3:0] in_tag;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_frac;
    logic [7:0] out_exp;
    logic [3:0] out_shift;
    logic       out_zero;
    logic       out_denorm;
    logic [3:0] out_tag;

    int checks = 0;
    int failures = 0;

    norm_shift_pipe #(.WIDTH(10), .EXP_W(8), .TAG_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_frac    (in_frac),
        .in_exp     (in_exp),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_frac   (out_frac),
        .out_exp    (out_exp),
        .out_shift  (out_shift),
        .out_zero   (out_zero),
        .out_denorm (out_denorm),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [9:0] frac;
        logic [7:0] exp;
        logic [9:0] efrac;
        logic [7:0] eexp;
        logic [3:0] eshift;
        logic       ezero;
        logic       eden;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_valid"}, out_valid, 0);
        chk({nm, "_frac"}, out_frac, 0);
        chk({nm, "_exp"}, out_exp, 0);
        chk({nm, "_shift"}, out_shift, 0);
        chk({nm, "_zero"}, out_zero, 0);
        chk({nm, "_denorm"}, out_denorm, 0);
        chk({nm, "_tag"}, out_tag, 0);
        chk({nm, "_in_ready"}, in_ready, 1);
    endtask

    initial begin
        int sent, rcv, first_c, last_c, n_out;
        bit saw_stall, prev_stall;
        logic [9:0] sv_frac;
        logic [3:0] sv_tag;
        logic [7:0] sv_exp;
        logic [3:0] pat;

        vecs[0]  = '{10'b0001011000, 8'd20,  10'b1011000000, 8'd17,  4'd3, 1'b0, 1'b0};
        vecs[1]  = '{10'b1000000001, 8'd5,   10'b1000000001, 8'd5,   4'd0, 1'b0, 1'b0};
        vecs[2]  = '{10'b0000010000, 8'd6,   10'b1000000000, 8'd1,   4'd5, 1'b0, 1'b0};
        vecs[3]  = '{10'b0000010000, 8'd3,   10'b0001000000, 8'd0,   4'd2, 1'b0, 1'b1};
        vecs[4]  = '{10'b0000000000, 8'd40,  10'b0000000000, 8'd0,   4'd0, 1'b1, 1'b0};
        vecs[5]  = '{10'b0011000000, 8'd0,   10'b0011000000, 8'd0,   4'd0, 1'b0, 1'b1};
        vecs[6]  = '{10'b0000000001, 8'd10,  10'b1000000000, 8'd1,   4'd9, 1'b0, 1'b0};
        vecs[7]  = '{10'b0000000001, 8'd1,   10'b0000000001, 8'd0,   4'd0, 1'b0, 1'b1};
        vecs[8]  = '{10'b1100000000, 8'd0,   10'b1100000000, 8'd0,   4'd0, 1'b0, 1'b0};
        vecs[9]  = '{10'b0100000000, 8'd255, 10'b1000000000, 8'd254, 4'd1, 1'b0, 1'b0};
        vecs[10] = '{10'b0000000001, 8'd9,   10'b0100000000, 8'd0,   4'd8, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; in_frac = '0; in_exp = '0; in_tag = '0; out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        chk_all_zero("reset");

        // Table-driven vectors, one at a time
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1; in_frac = vecs[i].frac; in_exp = vecs[i].exp;
            in_tag = 4'(i); out_ready = 1'b1;
            #1;
            chk("vec_in_ready", in_ready, 1);
            step();
            in_valid = 1'b0;
            chk("vec_lat1_valid", out_valid, 0);
            step();
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_frac", i), out_frac, vecs[i].efrac);
            chk($sformatf("vec%0d_exp", i), out_exp, vecs[i].eexp);
            chk($sformatf("vec%0d_shift", i), out_shift, vecs[i].eshift);
            chk($sformatf("vec%0d_zero", i), out_zero, vecs[i].ezero);
            chk($sformatf("vec%0d_denorm", i), out_denorm, vecs[i].eden);
            chk($sformatf("vec%0d_tag", i), out_tag, i);
        end
        step();

        // Backpressure: 6 tagged inputs, out_ready pattern 1,0,0,1
        pat = 4'b1001;
        sent = 0; rcv = 0; saw_stall = 0; prev_stall = 0;
        sv_frac = '0; sv_tag = '0; sv_exp = '0;
        for (int c = 0; c < 60 && rcv < 6; c++) begin
            out_ready = pat[c % 4];
            in_valid = (sent < 6);
            in_tag = 4'(sent);
            in_frac = 10'b1000000000 | 10'(sent);
            in_exp = 8'd5;
            #1;
            if (prev_stall) begin
                chk("bp_hold_frac", out_frac, sv_frac);
                chk("bp_hold_tag", out_tag, sv_tag);
                chk("bp_hold_exp", out_exp, sv_exp);
                chk("bp_hold_valid", out_valid, 1);
            end
            if (in_valid && !in_ready) saw_stall = 1;
            if (out_valid && out_ready) begin
                chk("bp_tag_order", out_tag, rcv);
                chk("bp_frac", out_frac, 10'b1000000000 | 10'(rcv));
                rcv++;
            end
            prev_stall = out_valid && !out_ready;
            sv_frac = out_frac; sv_tag = out_tag; sv_exp = out_exp;
            if (in_valid && in_ready) sent++;
            step();
        end
        in_valid = 1'b0;
        chk("bp_received", rcv, 6);
        chk("bp_in_ready_fell", int'(saw_stall), 1);
        out_ready = 1'b1;
        step();
        step();
        chk("bp_no_extra", out_valid, 0);

        // Full throughput: 16 back-to-back inputs
        sent = 0; rcv = 0; first_c = -1; last_c = -1; n_out = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            in_valid = (sent < 16);
            in_tag = 4'(sent);
            in_frac = 10'b0100000000;
            in_exp = 8'd10;
            #1;
            if (in_valid) chk("tp_in_ready", in_ready, 1);
            if (out_valid) begin
                if (first_c < 0) first_c = c;
                last_c = c;
                n_out++;
                chk("tp_tag_order", out_tag, rcv % 16);
                rcv++;
            end
            if (in_valid && in_ready) sent++;
            step();
        end
        in_valid = 1'b0;
        chk("tp_first_cycle", first_c, 2);
        chk("tp_count", n_out, 16);
        chk("tp_contiguous", last_c - first_c, 15);

        // Reset with both stages full
        out_ready = 1'b0;
        in_valid = 1'b1; in_tag = 4'd10; in_frac = 10'b0000000011; in_exp = 8'd30;
        step();
        in_tag = 4'd11;
        step();
        in_valid = 1'b0;
        chk("rstm_full_valid", out_valid, 1);
        chk("rstm_full_in_ready", in_ready, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk_all_zero("rstm");
        in_valid = 1'b1; in_frac = 10'b0001011000; in_exp = 8'd20; in_tag = 4'd7; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("rstm_lat1_valid", out_valid, 0);
        step();
        chk("rstm_lat2_valid", out_valid, 1);
        chk("rstm_tag", out_tag, 7);
        chk("rstm_frac", out_frac, 10'b1011000000);
        chk("rstm_exp", out_exp, 17);
        step();
        chk("rstm_drained", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
